// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- 8-way round-robin arbiter for a shared downstream resource.
//
// A rotating pointer selects where the priority search starts; the winner
// keeps the grant until it asserts done or drops its request. Every grant is
// followed by at least one idle cycle before the next arbitration.
//
// Optional watchdog: define ARB_TIMEOUT_EN to revoke a grant that has been
// held for TIMEOUT_CYCLES cycles (timeout pulses for one cycle). Without the
// macro there is no hold counter and timeout is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles one grant may be held (ARB_TIMEOUT_EN only)
//   CNT_W           hold-counter width, 2**CNT_W > TIMEOUT_CYCLES
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req[7:0]   in   request lines, one per requester
//   done       in   owner finished; only looked at while a grant is held
//   gnt[7:0]   out  one-hot registered grant
//   gnt_id     out  binary index of the current/last owner
//   gnt_valid  out  high while a grant is held (== |gnt)
//   timeout    out  one-cycle pulse when the watchdog revokes a grant
module rr_arbiter8 #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  if ((TIMEOUT_CYCLES == 0) || (TIMEOUT_CYCLES >= (1 << CNT_W))) begin : g_bad_cfg
    $error("rr_arbiter8: need 0 < TIMEOUT_CYCLES < 2**CNT_W");
  end

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [7:0] gnt_nx;
  logic [2:0] id_nx;
  logic       valid_nx;
  logic       timeout_nx;

  logic       found;
  logic [2:0] win;
  logic [2:0] idx;
  logic       release_now;
  logic       expire;

  // Rotated priority search: start at ptr, 3-bit index wraps 7 -> 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign release_now = done || !req[gnt_id];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;

  // Counter reads k-1 during the k-th held cycle, so the grant is revoked
  // at the edge ending its TIMEOUT_CYCLES-th cycle.
  assign expire = (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == GRANTED) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    gnt_nx     = gnt;
    id_nx      = gnt_id;
    valid_nx   = gnt_valid;
    timeout_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_nx   = 8'b1 << win;
          id_nx    = win;
          valid_nx = 1'b1;
          ptr_nx   = win + 3'd1;
          state_nx = GRANTED;
        end else begin
          gnt_nx   = '0;
          valid_nx = 1'b0;
        end
      end
      GRANTED: begin
        // Release has priority over the watchdog: no timeout pulse then.
        if (release_now || expire) begin
          gnt_nx     = '0;
          valid_nx   = 1'b0;
          state_nx   = IDLE;
          timeout_nx = !release_now;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      gnt       <= gnt_nx;
      gnt_id    <= id_nx;
      gnt_valid <= valid_nx;
      timeout   <= timeout_nx;
    end
  end

endmodule
